edge_threshold: RTL and testbench
=================================

// Module: edge_threshold
// PURPOSE
//  Downstream stage of the 3x3 edge convolution. Consumes edge-filtered RGB pixels over a dstream ready/valid link.
//  Computes per-pixel edge magnitude, binarises it against a frame-latched threshold and blanks the frame border.
//  Counts edge pixels per frame for the host/display. A 2-entry skid (output reg + skid reg) gives full throughput
//  with a registered x.ready.
// PARAMETERS
//  WIDTH    320  pixels per line
//  HEIGHT   240  lines per frame
//  W        30   pixel width; R=[29:22], G=[19:12], B=[9:2] (8-bit channels, 2 LSB pad each)
//  BORDER   1    border thickness in pixels, forced to 0 on every edge of the frame
//  CNT_W    $clog2(WIDTH*HEIGHT+1)   edge-count width (17 at defaults)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  x            dstream.in  data W / valid 1 / ready 1   edge-filtered pixel stream in
//  y            dstream.out data W / valid 1 / ready 1   binarised pixel stream out
//  threshold    in   10     magnitude threshold, 0..1023
//  edge_count   out  CNT_W  edge pixels in last completed frame
//  count_valid  out  1      one-cycle pulse when edge_count updates
// BEHAVIOUR
//  Reset (while reset=1, effective next edge):
//   - y.valid=0, y.data=0, skid empty, x.ready=0
//   - col=row=0, accumulator=0, edge_count=0, count_valid=0
//   - x.ready=1 the cycle after reset deasserts.
//  Accept: x.valid & x.ready. Emit: y.valid & y.ready.
//  Arithmetic:
//   - mag = R+G+B, 10-bit unsigned (max 765, no overflow).
//   - edge = (mag > thr_q), strict.
//  Threshold latch: thr_q <= threshold on accept of pixel (0,0). Pixel (0,0) itself uses the live threshold.
//   Changes mid-frame are ignored until the next (0,0).
//  Border: pixel is border if col<BORDER | col>=WIDTH-BORDER | row<BORDER | row>=HEIGHT-BORDER.
//   Border pixels: out = 0 and not counted.
//  Output data: edge & !border ? all-ones (30'h3FFFFFFF) : 0.
//  Position counters advance on accept only:
//   - col wraps WIDTH-1 -> 0 and increments row.
//   - row wraps HEIGHT-1 -> 0 (end of frame).
//  Pipeline/skid:
//   - Latency 1 cycle: pixel accepted at edge k appears on y at edge k+1 when the output reg is free.
//   - Output reg loads when (!y.valid | y.ready): from skid if skid valid, else from accepted input.
//     y.valid drops only when emitting with nothing to load.
//   - Accepted pixel while output reg is stalled (y.valid & !y.ready) goes to skid; x.ready <= 0 next cycle.
//   - x.ready is a register: x.ready = !skid_valid (next-state). Never combinationally depends on y.ready.
//   - y.data/y.valid hold stable while y.valid & !y.ready. Order preserved, no drop, no duplicate.
//  Frame count:
//   - Accumulator += (edge & !border) per accept.
//   - On accept of (WIDTH-1, HEIGHT-1): edge_count <= accumulator + this pixel's contribution; count_valid=1
//     for exactly 1 cycle (next edge); accumulator <= 0.
//  Reset mid-frame:
//   - In-flight output/skid pixels discarded; edge_count keeps its value (0 after reset).
//   - Partial frame never reported; next accepted pixel is (0,0).
//  Simultaneous emit + accept with skid empty: output reg takes new pixel, skid stays empty, full rate.
// TESTING (bench uses WIDTH=4, HEIGHT=3, BORDER=1 unless stated)
//  1. 12 pixels R=G=B=255, threshold=100, y.ready=1 -> only (1,1),(2,1) = 3FFFFFFF, rest 0;
//     edge_count=2, one count_valid pulse.
//  2. Interior pixel R=G=B=100 (mag 300): threshold=300 -> 0; threshold=299 (next frame) -> 3FFFFFFF.
//  3. x.valid=1 continuous, y.ready=0 for 5 cycles -> exactly 2 accepts, x.ready=0 from 2nd cycle,
//     y.data stable; release -> all pixels out in order, none lost.
//  4. threshold 100 at (0,0), changed to 1000 mid-frame -> frame still thresholded at 100;
//     next frame uses 1000 (edge_count=0).
//  5. reset for 1 cycle after 5 accepts -> y.valid=0, no count_valid;
//     next full 12-pixel frame gives correct count with (0,0) first.
//  6. Default params, random data, y.ready=1 -> 1 pixel/cycle, latency 1,
//     count_valid once per 76800 accepts, count matches model.

Source files
------------

// File: rtl/edge_threshold_if.sv
// edge_threshold_if
//   Ready/valid pixel stream link (dstream).
//   data  : W-bit pixel word, meaningful while valid=1
//   valid : source has a pixel on data
//   ready : sink takes the pixel on a clock edge where valid & ready
//   master modport drives data/valid, slave modport drives ready.
interface edge_threshold_if #(
  parameter int W = 30
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/edge_threshold.sv
// edge_threshold
//   Binarises edge-filtered RGB pixels: magnitude R+G+B is compared against a
//   threshold latched at the first pixel of each frame, the frame border is
//   blanked, and edge pixels are counted per frame.
// Ports
//   clk          single clock, posedge
//   reset        synchronous, active-high
//   x            slave stream in  (pixel, R=[29:22] G=[19:12] B=[9:2])
//   y            master stream out (all-ones for an edge pixel, else 0)
//   threshold    magnitude threshold, sampled on pixel (0,0)
//   edge_count   edge pixels in the last completed frame
//   count_valid  one-cycle pulse when edge_count updates
// Output register plus a one-entry skid keep full rate while x.ready stays a
// pure register output.
module edge_threshold #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int W      = 30,
  parameter int BORDER = 1,
  parameter int CNT_W  = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic             clk,
  input  logic             reset,
  edge_threshold_if.slave  x,
  edge_threshold_if.master y,
  input  logic [9:0]       threshold,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] COL_LO   = COL_W'(BORDER);
  localparam logic [COL_W-1:0] COL_HI   = COL_W'(WIDTH - BORDER);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(BORDER);
  localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(HEIGHT - BORDER);

  // Sum of the three 8-bit channels; 765 max, so 10 bits never overflow.
  function automatic logic [9:0] edge_mag(input logic [W-1:0] pix);
    return {2'b00, pix[29:22]} + {2'b00, pix[19:12]} + {2'b00, pix[9:2]};
  endfunction

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [9:0]       thr_q;
  logic [CNT_W-1:0] acc_q;
  logic             x_rdy_q;

  logic             accept, load, skid_nxt;
  logic             first_p0, last_p0, border_p0, bit_p0;
  logic [9:0]       thr_p0, mag_p0;

  logic             bit_p1, vld_p1;
  logic             bit_sk, vld_sk;

  // Channel pad bits carry no information.
  logic unused_pad;
  assign unused_pad = ^{x.data[21:20], x.data[11:10], x.data[1:0]};

  // ---- stage p0: decode of the pixel being accepted ----
  always_comb begin
    accept    = x.valid & x_rdy_q;
    load      = ~vld_p1 | y.ready;
    first_p0  = (col_q == '0) && (row_q == '0);
    last_p0   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    // Pixel (0,0) must see the live threshold, not the stale latched one.
    thr_p0    = first_p0 ? threshold : thr_q;
    mag_p0    = edge_mag(x.data);
    border_p0 = (col_q < COL_LO) | (col_q >= COL_HI) |
                (row_q < ROW_LO) | (row_q >= ROW_HI);
    bit_p0    = (mag_p0 > thr_p0) & ~border_p0;
    // Skid drains whenever the output register can load; it only fills when
    // a pixel is accepted while the output register is stalled.
    skid_nxt  = load ? 1'b0 : (accept | vld_sk);
  end

  // ---- stage p1: output register, skid, position and frame counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      x_rdy_q     <= 1'b0;
      vld_p1      <= 1'b0;
      bit_p1      <= 1'b0;
      vld_sk      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      x_rdy_q     <= ~skid_nxt;
      vld_sk      <= skid_nxt;
      count_valid <= 1'b0;

      if (load) begin
        if (vld_sk) begin
          bit_p1 <= bit_sk;
          vld_p1 <= 1'b1;
        end else if (accept) begin
          bit_p1 <= bit_p0;
          vld_p1 <= 1'b1;
        end else begin
          vld_p1 <= 1'b0;
        end
      end

      if (accept) begin
        if (first_p0) thr_q <= threshold;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (last_p0) begin
          edge_count  <= acc_q + CNT_W'(bit_p0);
          count_valid <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_q + CNT_W'(bit_p0);
        end
      end
    end
  end

  // Skid payload needs no reset: it is only read while vld_sk is set.
  always_ff @(posedge clk) begin
    if (accept & ~load) bit_sk <= bit_p0;
  end

  assign x.ready = x_rdy_q;
  assign y.valid = vld_p1;
  assign y.data  = {W{bit_p1}};

endmodule

// File: tb/tb_edge_threshold.sv
// tb_edge_threshold
//   Drives a 4x3 instance through directed frames and a 320x240 instance with
//   random pixels; a position-based reference model predicts every output
//   pixel and every frame count.
module tb_edge_threshold;
  localparam int SW = 4;
  localparam int SH = 3;
  localparam int BW = 320;
  localparam int BH = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset = 1'b1;
  logic        xv    = 1'b0;
  logic [29:0] xd    = '0;
  logic        yr    = 1'b1;
  logic [9:0]  thr   = '0;

  edge_threshold_if #(.W(30)) xs ();
  edge_threshold_if #(.W(30)) ys ();
  edge_threshold_if #(.W(30)) xb ();
  edge_threshold_if #(.W(30)) yb ();

  assign xs.valid = xv;
  assign xs.data  = xd;
  assign ys.ready = yr;
  assign xb.valid = xv;
  assign xb.data  = xd;
  assign yb.ready = yr;

  logic [3:0]  ec_s;
  logic        cv_s;
  logic [16:0] ec_b;
  logic        cv_b;

  edge_threshold #(.WIDTH(SW), .HEIGHT(SH), .W(30), .BORDER(1)) dut_s (
    .clk(clk), .reset(reset), .x(xs), .y(ys), .threshold(thr),
    .edge_count(ec_s), .count_valid(cv_s)
  );

  edge_threshold #(.WIDTH(BW), .HEIGHT(BH), .W(30), .BORDER(1)) dut_b (
    .clk(clk), .reset(reset), .x(xb), .y(yb), .threshold(thr),
    .edge_count(ec_b), .count_valid(cv_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed DUT selected for modelling
  bit          sel_big = 1'b0;
  int          fw = SW;
  int          fh = SH;
  logic        m_xr, m_yv, m_cv;
  logic [29:0] m_yd;
  logic [16:0] m_ec;

  always_comb begin
    m_xr = sel_big ? xb.ready : xs.ready;
    m_yv = sel_big ? yb.valid : ys.valid;
    m_yd = sel_big ? yb.data  : ys.data;
    m_cv = sel_big ? cv_b     : cv_s;
    m_ec = sel_big ? ec_b     : {13'd0, ec_s};
  end

  // Reference model state
  bit          mon_en  = 1'b0;
  bit          lat_chk = 1'b0;
  int          m_idx   = 0;
  int          m_acc   = 0;
  int          m_thr   = 0;
  int          acc_cnt = 0;
  bit          exp_q[$];
  int          cnt_q[$];
  bit          prev_acc   = 1'b0;
  bit          prev_stall = 1'b0;
  logic [29:0] prev_yd    = '0;

  always @(negedge clk) begin : monitor
    bit acc, emit, e, bd, eb;
    int col, row, mag, ce;
    if (mon_en && !reset) begin
      acc  = xv && m_xr;
      emit = m_yv && yr;
      if (prev_stall) begin
        check("hold_valid", 32'(m_yv), 32'd1);
        check("hold_data", 32'(m_yd), 32'(prev_yd));
      end
      if (lat_chk && prev_acc) check("latency", 32'(m_yv), 32'd1);
      if (m_cv) begin
        check("cv_pending", 32'(cnt_q.size() > 0), 32'd1);
        if (cnt_q.size() > 0) begin
          ce = cnt_q.pop_front();
          check("edge_count", 32'(m_ec), ce);
        end
      end
      if (emit) begin
        check("emit_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          check("y_data", 32'(m_yd), eb ? 32'h3FFF_FFFF : 32'd0);
        end
      end
      if (acc) begin
        col = m_idx % fw;
        row = m_idx / fw;
        if (m_idx == 0) m_thr = int'(thr);
        mag = int'(xd[29:22]) + int'(xd[19:12]) + int'(xd[9:2]);
        e   = mag > m_thr;
        bd  = (col < 1) || (col >= fw - 1) || (row < 1) || (row >= fh - 1);
        exp_q.push_back(e && !bd);
        if (e && !bd) m_acc++;
        if (m_idx == fw * fh - 1) begin
          cnt_q.push_back(m_acc);
          m_acc = 0;
          m_idx = 0;
        end else begin
          m_idx++;
        end
        acc_cnt++;
      end
      prev_acc   = acc;
      prev_stall = m_yv && !yr;
      prev_yd    = m_yd;
    end else begin
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end
  end

  function automatic logic [29:0] pix(input int r, input int g, input int b);
    logic [7:0] r8, g8, b8;
    r8 = 8'(r);
    g8 = 8'(g);
    b8 = 8'(b);
    return {r8, 2'($urandom), g8, 2'($urandom), b8, 2'($urandom)};
  endfunction

  // mode 0: all channels 255, mode 1: all channels 100, mode 2: random
  task automatic send(input int n, input int mode, input int chg_at, input logic [9:0] chg_thr);
    bit a;
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) thr = chg_thr;
      case (mode)
        0:       xd = pix(255, 255, 255);
        1:       xd = pix(100, 100, 100);
        default: xd = pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      endcase
      xv = 1'b1;
      t  = 0;
      do begin
        @(negedge clk);
        a = xv && m_xr;
        @(posedge clk);
        #1;
        t++;
      end while (!a && t < 200);
      if (!a) begin
        check("accept_timeout", 32'(a), 32'd1);
        break;
      end
    end
    xv = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("pixels_pending", 32'(exp_q.size()), 32'd0);
    check("counts_pending", 32'(cnt_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_idx = 0;
    m_acc = 0;
    exp_q.delete();
    cnt_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : main
    int c0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x_ready", 32'(m_xr), 32'd0);
    check("rst_y_valid", 32'(m_yv), 32'd0);
    check("rst_y_data", 32'(m_yd), 32'd0);
    check("rst_edge_count", 32'(m_ec), 32'd0);
    check("rst_count_valid", 32'(m_cv), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("x_ready_after_rst", 32'(m_xr), 32'd1);
    mon_en = 1'b1;

    // full-white frame: only the two interior pixels are edges
    thr = 10'd100;
    send(12, 0, -1, '0);
    drain();
    check("t1_count", 32'(m_ec), 32'd2);

    // strict compare at the threshold
    thr = 10'd300;
    send(12, 1, -1, '0);
    drain();
    check("t2_thr300", 32'(m_ec), 32'd0);
    thr = 10'd299;
    send(12, 1, -1, '0);
    drain();
    check("t2_thr299", 32'(m_ec), 32'd2);

    // output stall with continuous input
    thr = 10'd100;
    acc_cnt = 0;
    fork
      send(12, 0, -1, '0);
      begin
        yr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t3_accepts", 32'(acc_cnt), 32'd2);
        check("t3_x_ready", 32'(m_xr), 32'd0);
        yr = 1'b1;
      end
    join
    drain();
    check("t3_count", 32'(m_ec), 32'd2);

    // threshold change mid-frame only applies from the next frame
    thr = 10'd100;
    send(12, 0, 3, 10'd1000);
    drain();
    check("t4_old_thr", 32'(m_ec), 32'd2);
    send(12, 0, -1, '0);
    drain();
    check("t4_new_thr", 32'(m_ec), 32'd0);

    // reset in the middle of a frame
    thr = 10'd100;
    send(5, 0, -1, '0);
    apply_reset();
    check("t5_y_valid", 32'(m_yv), 32'd0);
    check("t5_count_valid", 32'(m_cv), 32'd0);
    check("t5_edge_count", 32'(m_ec), 32'd0);
    send(12, 0, -1, '0);
    drain();
    check("t5_count", 32'(m_ec), 32'd2);

    // default geometry, random pixels at full rate
    sel_big = 1'b1;
    fw = BW;
    fh = BH;
    apply_reset();
    @(posedge clk);
    #1;
    thr = 10'($urandom_range(200, 560));
    lat_chk = 1'b1;
    acc_cnt = 0;
    c0 = cyc;
    send(BW * BH, 2, -1, '0);
    check("t6_rate", 32'(cyc - c0), 32'(BW * BH));
    lat_chk = 1'b0;
    drain();
    check("t6_accepts", 32'(acc_cnt), 32'(BW * BH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
